// File: rtl/ysyx_22040127_pkg.sv
// Shared definitions for the iterative divider: datapath width, iteration counts, FSM states.
package ysyx_22040127_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [CNT_W-1:0] ITER_D = 7'd64;
  localparam logic [CNT_W-1:0] ITER_W = 7'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040127_div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module ysyx_22040127_div_step
  import ysyx_22040127_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN-1:0] w_shift;
  logic            w_ge;

  // i_rem[XLEN-1] set means the shifted value is >= 2^XLEN, above any divisor.
  always_comb begin
    w_shift = {i_rem[XLEN-2:0], i_bit};
    w_ge    = i_rem[XLEN-1] | (w_shift >= i_div);
    o_qbit  = w_ge;
    o_rem   = w_ge ? (w_shift - i_div) : w_shift;
  end

endmodule

// File: rtl/ysyx_22040127_divider.sv
// Iterative restoring divider for RV64 div/divu/rem/remu and *w variants.
// Optional macro YSYX_22040127_DIV_FASTPATH_EN: divide-by-zero and signed overflow skip iteration.
module ysyx_22040127_divider
  import ysyx_22040127_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [XLEN-1:0] OVF_D = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] OVF_W = 64'hFFFF_FFFF_8000_0000;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  div_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_quo, r_rem, r_div;
  logic             r_neg_q, r_neg_r, r_word;

  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_mag_a, w_mag_b;
  logic             w_sa, w_sb, w_dbz, w_accept;
  logic [XLEN-1:0]  w_step_rem;
  logic             w_step_q;
  logic [XLEN-1:0]  w_q_mag, w_q_fix, w_r_fix;

  // Operand conditioning at acceptance: word extension, then signed magnitudes
  always_comb begin
    w_a_ext = div_word ? (div_signed ? sext32(src1[31:0]) : {32'b0, src1[31:0]}) : src1;
    w_b_ext = div_word ? (div_signed ? sext32(src2[31:0]) : {32'b0, src2[31:0]}) : src2;
    w_sa    = div_signed & w_a_ext[XLEN-1];
    w_sb    = div_signed & w_b_ext[XLEN-1];
    w_mag_a = cond_neg(w_a_ext, w_sa);
    w_mag_b = cond_neg(w_b_ext, w_sb);
    w_dbz   = (w_b_ext == '0);
  end

`ifdef YSYX_22040127_DIV_FASTPATH_EN
  logic w_ovf, w_fast;
  assign w_ovf  = div_signed & (w_b_ext == '1) & (w_a_ext == (div_word ? OVF_W : OVF_D));
  assign w_fast = w_dbz | w_ovf;
`else
  logic w_fast;
  assign w_fast = 1'b0;
`endif

  assign div_ready = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = div_valid & div_ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt <= 7'd1) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  ysyx_22040127_div_step u_step (
    .i_rem  (r_rem),
    .i_bit  (r_quo[XLEN-1]),
    .i_div  (r_div),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_q)
  );

  // Load / iterate. A zero divisor naturally yields all-ones quotient bits; the
  // quotient sign is suppressed for it so the result stays -1 for signed ops.
  // Fast-path ops load the final magnitudes with a zero count (one BUSY cycle, no step).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_word  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_div   <= w_mag_b;
      r_neg_q <= (w_sa ^ w_sb) & ~w_dbz;
      r_neg_r <= w_sa;
      r_word  <= div_word;
      if (w_fast) begin
        r_cnt <= '0;
        r_quo <= w_dbz ? '1 : w_mag_a;
        r_rem <= w_dbz ? w_mag_a : '0;
      end else begin
        r_cnt <= div_word ? ITER_W : ITER_D;
        r_quo <= div_word ? {w_mag_a[31:0], 32'b0} : w_mag_a;
        r_rem <= '0;
      end
    end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
      r_rem <= w_step_rem;
      r_quo <= {r_quo[XLEN-2:0], w_step_q};
      r_cnt <= r_cnt - 7'd1;
    end
  end

  // Sign correction and word sign-extension on the stored magnitudes
  always_comb begin
    w_q_mag   = r_word ? {32'b0, r_quo[31:0]} : r_quo;
    w_q_fix   = cond_neg(w_q_mag, r_neg_q);
    w_r_fix   = cond_neg(r_rem, r_neg_r);
    quotient  = r_word ? sext32(w_q_fix[31:0]) : w_q_fix;
    remainder = r_word ? sext32(w_r_fix[31:0]) : w_r_fix;
  end

endmodule

// File: tb/tb_ysyx_22040127_divider.sv
// Scoreboard bench for ysyx_22040127_divider: directed vectors, monitor checks results and latency.
module tb_ysyx_22040127_divider;

`ifdef YSYX_22040127_DIV_FASTPATH_EN
  localparam int FL_D = 1;
  localparam int FL_W = 1;
`else
  localparam int FL_D = 64;
  localparam int FL_W = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_valid = 1'b0, div_signed = 1'b0, div_word = 1'b0;
  logic        flush = 1'b0, out_ready = 1'b1;
  logic [63:0] src1 = '0, src2 = '0;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vcyc = 0;
  bit   seen = 1'b0;

  ysyx_22040127_divider dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_word   (div_word),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: first-valid cycle gives latency; pops on the handshake cycle
  always @(negedge clk) begin
    if (!out_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        vcyc = cyc;
      end
      if (out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out actual q=%h r=%h required none", quotient, remainder);
        end else begin
          mon_e = sbq.pop_front();
          chk({mon_e.nm, "_q"}, quotient, mon_e.q);
          chk({mon_e.nm, "_r"}, remainder, mon_e.r);
          chk({mon_e.nm, "_lat"}, 64'(vcyc - mon_e.acc), 64'(mon_e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  task automatic drive_req(input logic sg, input logic wd, input logic [63:0] a,
                           input logic [63:0] b, output int acc);
    int w = 0;
    while (!div_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait", 64'(div_ready), 64'd1);
    div_valid = 1'b1; div_signed = sg; div_word = wd; src1 = a; src2 = b;
    @(posedge clk); #1;
    acc = cyc;
    div_valid = 1'b0;
  endtask

  task automatic issue(input string nm, input logic sg, input logic wd, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                       input int lat);
    int   acc;
    exp_t e;
    drive_req(sg, wd, a, b, acc);
    e.q = eq; e.r = er; e.lat = lat; e.acc = acc; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((sbq.size() != 0 || !div_ready) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic wait_valid(input string nm);
    int w = 0;
    while (!out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk(nm, 64'(out_valid), 64'd1);
  endtask

  task automatic watch_quiet(input string nm, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk(nm, 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 64'(div_ready), 64'd1);
    chk("rel_valid", 64'(out_valid), 64'd0);

    issue("divu_100_7",   0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    issue("div_m7_2",     1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    issue("remw_m7_2",    1, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    issue("div_5_0",      1, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, FL_D);
    issue("div_ovf",      1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, FL_D);
    issue("divuw_ff_1",   0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32);
    issue("divu_big",     0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16,
          64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 64);
    issue("divu_3_max",   0, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd3, 64);
    issue("rem_7_m2",     1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64);
    issue("divw_ovf",     1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'd0, FL_W);
    issue("divw_m7_0",    1, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, FL_W);
    issue("divu_5_0",     0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, FL_D);
    issue("divuw_upper",  0, 1, 64'hDEAD_BEEF_0000_0064, 64'hFFFF_FFFF_0000_0007,
          64'd14, 64'd2, 32);
    wait_drain();

    // Consumer stall in DONE
    out_ready = 1'b0;
    issue("stall", 0, 0, 64'd1000, 64'd10, 64'd100, 64'd0, 64);
    wait_valid("stall_valid_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_q", quotient, 64'd100);
      chk("stall_r", remainder, 64'd0);
      chk("stall_ready", 64'(div_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_rel_ready", 64'(div_ready), 64'd1);
    chk("stall_rel_valid", 64'(out_valid), 64'd0);
    wait_drain();

    // Flush at step 20 of BUSY
    drive_req(0, 0, 64'd1000, 64'd3, acc);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(div_ready), 64'd1);
    watch_quiet("flush_quiet", 80);

    // Flush wins over a simultaneous request
    div_valid = 1'b1; div_signed = 1'b0; div_word = 1'b0; src1 = 64'd50; src2 = 64'd5;
    flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    chk("flushreq_ready", 64'(div_ready), 64'd1);
    watch_quiet("flushreq_quiet", 70);

    // Reset mid-BUSY
    drive_req(0, 0, 64'd77, 64'd7, acc);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rstb_ready", 64'(div_ready), 64'd1);
    watch_quiet("rstb_quiet", 70);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    drive_req(0, 0, 64'd9, 64'd2, acc);
    wait_valid("rstd_valid_wait");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstd_valid", 64'(out_valid), 64'd0);
    chk("rstd_q", quotient, 64'd0);
    chk("rstd_r", remainder, 64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rstd_ready", 64'(div_ready), 64'd1);

    issue("after_9_3", 0, 0, 64'd9, 64'd3, 64'd3, 64'd0, 64);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_divider.md
YSYX_22040127_DIVIDER -- requirements
Module: ysyx_22040127_divider

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous active-low reset; 0 = reset, sampled on clk rising edge.
REQ-003 SHALL have port div_valid, input, 1: execute stage presents a divide request.
REQ-004 SHALL have port div_ready, output, 1: divider accepts a request; high only in IDLE.
REQ-005 SHALL have port div_signed, input, 1: 1 = div/rem/divw/remw; 0 = unsigned variants.
REQ-006 SHALL have port div_word, input, 1: 1 = *w variant; operates on src[31:0].
REQ-007 SHALL have port src1, input, 64: dividend.
REQ-008 SHALL have port src2, input, 64: divisor.
REQ-009 SHALL have port flush, input, 1: abort current operation.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-012 SHALL have port quotient, output, 64: final quotient; *w variants sign-extended from bit 31.
REQ-013 SHALL have port remainder, output, 64: final remainder; *w variants sign-extended from bit 31.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; request accepted on an edge where div_valid & div_ready & flush=0.
REQ-015 SHALL latch operands at acceptance: word ops sign-extend (signed) or zero-extend (unsigned) [31:0]; signed ops convert operands to magnitudes and record quotient sign (s1^s2) and remainder sign (s1).
REQ-016 SHALL perform one radix-2 restoring step per BUSY cycle: N=64 steps (64-bit ops), N=32 steps (word ops); iteration counter 7 bits, counts down to 0.
REQ-017 SHALL enter DONE on the edge completing step N; out_valid rises N clock edges after the accepting edge.
REQ-018 SHALL apply sign correction combinationally in DONE; quotient/remainder stable while out_valid=1.
REQ-019 SHALL leave DONE for IDLE on an edge with out_ready=1; div_ready=0 in DONE (no same-cycle re-accept).
REQ-020 Divide by zero SHALL yield quotient = all ones (-1), remainder = dividend (after word sign-extension), for signed and unsigned.
REQ-021 Signed overflow (64-bit: 0x8000000000000000 / -1; word: 0x80000000 / -1) SHALL yield quotient = dividend, remainder = 0.
REQ-022 flush=1 SHALL force IDLE on that edge from any state, out_valid low next cycle; flush wins over simultaneous div_valid.
REQ-023 Outputs quotient/remainder SHALL be don't-care when out_valid=0; out_valid SHALL never assert outside DONE.

Reset
REQ-024 rst=0 SHALL force IDLE, counter 0, out_valid=0, quotient=0, remainder=0; div_ready=1 on the first cycle after release.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL discard the operation without producing out_valid.

Configuration
REQ-026 Macro YSYX_22040127_DIV_FASTPATH_EN defined: divide-by-zero and signed overflow bypass BUSY, entering DONE on the edge after acceptance (out_valid 1 edge after accept).
REQ-027 Macro undefined: those cases SHALL run the full N iterations with identical results per REQ-020/021.

Structure
REQ-028 Shared package ysyx_22040127_pkg SHALL hold FSM state encodings, XLEN=64, and iteration counts 64/32.
REQ-029 One sub-module ysyx_22040127_div_step SHALL implement a single combinational restoring step (partial remainder, divisor -> next remainder, quotient bit).

Verification
REQ-030 divu 100 / 7 -> quotient 14, remainder 2; out_valid 64 edges after accept.
REQ-031 div -7 / 2 -> quotient -3 (0xFFFFFFFFFFFFFFFD), remainder -1; remw 0xFFFFFFF9 % 2 -> remainder 0xFFFFFFFFFFFFFFFF, out_valid 32 edges after accept.
REQ-032 div 5 / 0 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 5; div 0x8000000000000000 / -1 -> quotient 0x8000000000000000, remainder 0; latency 1 edge with FASTPATH_EN, 64 edges without.
REQ-033 divuw 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFFFFFFFFFF (sign-extended), remainder 0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid and results stable, div_ready=0; then out_ready=1 -> IDLE, div_ready=1 next cycle.
REQ-035 flush at step 20 of BUSY, and rst=0 in DONE -> IDLE next edge, no out_valid; next request 9/3 -> quotient 3, remainder 0.
